gpio_vector_recorder: RTL and testbench

//  Writer side of the GPIO test-vector format consumed by our vector benches.
//  - On each sample strobe, captures one record {cpu reset, gpio_in, gpio_out}

---
 rtl/gpio_vector_recorder.sv | 116 +++++++++++
 tb/tb_gpio_vector_recorder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_vector_recorder.sv
// GPIO test-vector recorder: captures {cpu_rst, gpio_in, gpio_out} records into a FIFO
// and streams each one out as an 18-character ASCII hex line.
module gpio_vector_recorder #(
   parameter int DEPTH     = 16,
   parameter int ADDR_W    = 4,
   parameter bit UPPERCASE = 1'b0
) (
   input  logic              clk2,
   input  logic              rst,
   input  logic              sample,
   input  logic              cpu_rst,
   input  logic [31:0]       gpio_in,
   input  logic [31:0]       gpio_out,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic [ADDR_W:0]   fifo_level,
   output logic              overflow,
   output logic [31:0]       rec_count
);

   typedef enum logic {IDLE, EMIT} state_t;

   localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W + 1)'(DEPTH);
   localparam logic [4:0]      IDX_LAST   = 5'd17;
   localparam logic [7:0]      LETTER_A   = UPPERCASE ? 8'h41 : 8'h61;

   state_t              state, state_nxt;
   logic [64:0]         mem [DEPTH];
   logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
   logic [64:0]         rec;
   logic [4:0]          idx;
   logic                full, empty, push, pop, hs, last;
   logic [67:0]         rec_ext;
   logic [6:0]          nib_shift;
   logic [3:0]          nib;
   logic [7:0]          nib_char;

   assign full     = (fifo_level == LEVEL_FULL);
   assign empty    = (fifo_level == '0);
   assign push     = sample & ~full;
   assign tx_valid = (state == EMIT);
   assign hs       = tx_valid & tx_ready;
   assign last     = (idx == IDX_LAST);

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = EMIT;
            end
         end
         EMIT: begin
            // Newline accepted: chain straight into the next record if one is waiting.
            if (hs && last) begin
               if (!empty) pop = 1'b1;
               else        state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk2) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk2) begin
      if (push) mem[wr_ptr] <= {cpu_rst, gpio_in, gpio_out};
   end

   always_ff @(posedge clk2) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
         rec_count  <= '0;
         idx        <= '0;
         rec        <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            rec    <= mem[rd_ptr];
            idx    <= '0;
         end else if (hs && !last) begin
            idx <= idx + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
         if (sample && full) overflow <= 1'b1;
         if (hs && last)     rec_count <= rec_count + 1'b1;
      end
   end

   // Padding the reset bit to a nibble lets all 17 hex characters share one shifter.
   assign rec_ext   = {3'b000, rec};
   assign nib_shift = 7'd64 - {idx, 2'b00};
   assign nib       = 4'(rec_ext >> nib_shift);
   assign nib_char  = (nib < 4'd10) ? (8'h30 + {4'h0, nib})
                                    : (LETTER_A + {4'h0, nib} - 8'd10);

   always_comb begin
      tx_data = 8'h00;
      if (state == EMIT) tx_data = last ? 8'h0A : nib_char;
   end

endmodule

// File: tb/tb_gpio_vector_recorder.sv
// Bench for gpio_vector_recorder: directed scenarios plus random traffic, all checked
// every cycle against a queue-of-lines reference model.
module tb_gpio_vector_recorder;

   localparam int DEPTH = 16;

   logic        clk2 = 1'b0;
   logic        rst = 1'b0;
   logic        sample = 1'b0;
   logic        cpu_rst = 1'b0;
   logic [31:0] gpio_in = '0;
   logic [31:0] gpio_out = '0;
   logic        tx_ready = 1'b0;

   logic [7:0]  tx_data, tx_data_u;
   logic        tx_valid, tx_valid_u;
   logic [4:0]  fifo_level, fifo_level_u;
   logic        overflow, overflow_u;
   logic [31:0] rec_count, rec_count_u;

   gpio_vector_recorder #(.DEPTH(DEPTH), .ADDR_W(4), .UPPERCASE(1'b0)) dut (
      .clk2(clk2), .rst(rst), .sample(sample), .cpu_rst(cpu_rst),
      .gpio_in(gpio_in), .gpio_out(gpio_out), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .fifo_level(fifo_level), .overflow(overflow),
      .rec_count(rec_count)
   );

   gpio_vector_recorder #(.DEPTH(DEPTH), .ADDR_W(4), .UPPERCASE(1'b1)) dut_u (
      .clk2(clk2), .rst(rst), .sample(sample), .cpu_rst(cpu_rst),
      .gpio_in(gpio_in), .gpio_out(gpio_out), .tx_data(tx_data_u), .tx_valid(tx_valid_u),
      .tx_ready(tx_ready), .fifo_level(fifo_level_u), .overflow(overflow_u),
      .rec_count(rec_count_u)
   );

   always #5 clk2 = ~clk2;

   int n_checks = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference model: FIFO of formatted text lines plus the line currently being sent.
   string       m_fifo[$];
   bit          m_busy = 1'b0;
   string       m_line = "";
   int          m_pos = 0;
   bit          m_ovf = 1'b0;
   int unsigned m_count = 0;

   string       got = "";
   string       got_u = "";
   string       exp_all = "";
   bit          prev_valid = 1'b0;
   bit          prev_valid_u = 1'b0;
   logic [7:0]  prev_data = '0;
   logic [7:0]  prev_data_u = '0;
   int          cyc = 0;
   int          first_v = -1;
   int          last_v = -1;

   function automatic string fmt_line(input bit cr, input logic [31:0] a, input logic [31:0] b);
      return $sformatf("%0d%08h%08h\n", int'(cr), a, b);
   endfunction

   task automatic model_edge();
      int sz;
      bit take;
      string line;
      if (!rst) begin
         m_fifo.delete();
         m_busy  = 1'b0;
         m_pos   = 0;
         m_ovf   = 1'b0;
         m_count = 0;
         return;
      end
      if (prev_valid && tx_ready)   got   = $sformatf("%s%c", got, prev_data);
      if (prev_valid_u && tx_ready) got_u = $sformatf("%s%c", got_u, prev_data_u);
      sz   = m_fifo.size();
      take = 1'b0;
      if (m_busy) begin
         if (tx_ready) begin
            if (m_pos == 17) begin
               m_count++;
               m_busy = 1'b0;
               take   = (sz > 0);
            end else begin
               m_pos++;
            end
         end
      end else begin
         take = (sz > 0);
      end
      if (sample) begin
         if (sz == DEPTH) m_ovf = 1'b1;
         else begin
            line = fmt_line(cpu_rst, gpio_in, gpio_out);
            m_fifo.push_back(line);
            exp_all = {exp_all, line};
         end
      end
      if (take) begin
         m_line = m_fifo.pop_front();
         m_busy = 1'b1;
         m_pos  = 0;
      end
   endtask

   task automatic compare_all();
      string lu;
      cyc++;
      lu = m_line.toupper();
      check("tx_valid", tx_valid, m_busy);
      check("tx_valid_uc", tx_valid_u, m_busy);
      check("tx_data", tx_data, m_busy ? m_line[m_pos] : 8'h00);
      check("tx_data_uc", tx_data_u, m_busy ? lu[m_pos] : 8'h00);
      check("fifo_level", fifo_level, m_fifo.size());
      check("overflow", overflow, m_ovf);
      check("rec_count", rec_count, m_count);
      prev_valid   = tx_valid;
      prev_data    = tx_data;
      prev_valid_u = tx_valid_u;
      prev_data_u  = tx_data_u;
      if (tx_valid) begin
         if (first_v < 0) first_v = cyc;
         last_v = cyc;
      end
   endtask

   task automatic step();
      @(posedge clk2);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      sample = 1'b0;
      tx_ready = 1'b0;
      step();
      step();
      rst = 1'b1;
      got = "";
      got_u = "";
      exp_all = "";
      first_v = -1;
      last_v = -1;
   endtask

   task automatic randomize_data();
      cpu_rst  = 1'($urandom_range(0, 1));
      gpio_in  = $urandom;
      gpio_out = $urandom;
   endtask

   task automatic drain(input int budget, input bit rnd_ready);
      int n = 0;
      sample = 1'b0;
      while ((m_busy || m_fifo.size() > 0) && n < budget) begin
         if (rnd_ready) tx_ready = 1'($urandom_range(0, 1));
         step();
         n++;
      end
      if (m_busy || m_fifo.size() > 0) check("drain_timeout", 1, 0);
   endtask

   initial begin
      // Reset state
      do_reset();
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_fifo_level", fifo_level, 0);
      check("rst_rec_count", rec_count, 0);

      // Single record, unstalled
      tx_ready = 1'b1;
      cpu_rst  = 1'b0;
      gpio_in  = 32'h0002_6789;
      gpio_out = 32'h0002_6789;
      sample   = 1'b1;
      step();
      check("t1_valid_at_capture", tx_valid, 0);
      sample = 1'b0;
      step();
      check("t1_valid_rise", tx_valid, 1);
      drain(40, 1'b0);
      check("t1_stream", got == "00002678900026789\n", 1);
      check("t1_rec_count", rec_count, 1);

      // Letter case
      do_reset();
      tx_ready = 1'b1;
      cpu_rst  = 1'b1;
      gpio_in  = 32'h0003_FFFF;
      gpio_out = 32'h05F5_E0FF;
      sample   = 1'b1;
      step();
      drain(40, 1'b0);
      check("t2_lower", got == "10003ffff05f5e0ff\n", 1);
      check("t2_upper", got_u == "10003FFFF05F5E0FF\n", 1);

      // Three samples with random backpressure
      do_reset();
      for (int i = 0; i < 3; i++) begin
         randomize_data();
         sample   = 1'b1;
         tx_ready = 1'($urandom_range(0, 1));
         step();
      end
      drain(400, 1'b1);
      check("t3_len", got.len(), 54);
      check("t3_stream", got == exp_all, 1);

      // Overflow while stalled
      do_reset();
      tx_ready = 1'b0;
      for (int i = 0; i < 18; i++) begin
         randomize_data();
         sample = 1'b1;
         step();
      end
      check("t4_level_full", fifo_level, 16);
      check("t4_overflow", overflow, 1);
      check("t4_emitting", tx_valid, 1);
      tx_ready = 1'b1;
      drain(600, 1'b0);
      check("t4_lines", rec_count, 17);
      check("t4_len", got.len(), 17 * 18);
      check("t4_stream", got == exp_all, 1);

      // Reset mid-line
      do_reset();
      tx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         randomize_data();
         sample = 1'b1;
         step();
      end
      sample = 1'b0;
      begin
         int n = 0;
         while (!(m_busy && m_pos == 9) && n < 50) begin
            step();
            n++;
         end
      end
      check("t5_at_idx9", tx_valid && m_pos == 9, 1);
      check("t5_queued", fifo_level, 2);
      rst = 1'b0;
      step();
      check("t5_valid_low", tx_valid, 0);
      check("t5_level_zero", fifo_level, 0);
      check("t5_count_zero", rec_count, 0);
      rst = 1'b1;
      got = "";
      repeat (30) step();
      check("t5_silent", got.len(), 0);

      // Sample held high, no bubbles between lines
      do_reset();
      tx_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         randomize_data();
         sample = 1'b1;
         step();
      end
      drain(600, 1'b0);
      check("t6_lines", rec_count, 17);
      check("t6_overflow", overflow, 1);
      check("t6_span", last_v - first_v + 1, 17 * 18);
      check("t6_len", got.len(), 17 * 18);
      check("t6_stream", got == exp_all, 1);

      // Random traffic
      do_reset();
      for (int i = 0; i < 400; i++) begin
         randomize_data();
         sample   = ($urandom_range(0, 2) == 0);
         tx_ready = 1'($urandom_range(0, 1));
         step();
      end
      drain(800, 1'b1);
      check("t7_stream", got == exp_all, 1);
      check("t7_stream_uc", got_u == exp_all.toupper(), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
